// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the request legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

  // Encoded as {mem_write, mem_read}.
  typedef enum logic [1:0] {
    ACC_NONE  = 2'b00,
    ACC_LOAD  = 2'b01,
    ACC_STORE = 2'b10,
    ACC_BOTH  = 2'b11
  } acc_t;

  // True when the access may touch the RAM: known opcode, natural alignment, in range.
  function automatic logic is_legal(input acc_t acc, input logic [2:0] funct3,
                                    input logic [31:0] addr, input int unsigned depth);
    logic ok;
    ok = 1'b0;
    case (acc)
      ACC_LOAD:  ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      ACC_STORE: ok = funct3 inside {F3_B, F3_H, F3_W};
      default:   ok = 1'b0;
    endcase
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ok = 1'b0;
    if (funct3 == F3_W && addr[1:0] != 2'b00) ok = 1'b0;
    if ({2'b00, addr[31:2]} >= depth) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering between a 32-bit RAM word and RV32I load/store operands.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] lword
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select lanes, replicate store data across lanes and extend load data.
  always_comb begin
    lane_b = 8'(rword >> {addr_lo, 3'b000});
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    be     = 4'b0000;
    wword  = wdata;
    lword  = rword;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        lword = {{24{lane_b[7]}}, lane_b};
      end
      F3_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        lword = {{16{lane_h[15]}}, lane_h};
      end
      F3_W: begin
        be    = 4'b1111;
        wword = wdata;
        lword = rword;
      end
      F3_BU: lword = {24'b0, lane_b};
      F3_HU: lword = {16'b0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM serving RV32I loads/stores with LAT wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [31:0] mem [DEPTH];

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          wr_q, wr_d;
  logic          bad_q, bad_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        req, legal, mem_we;
  acc_t        acc;
  logic [31:0] rword, wword, lword;
  logic [3:0]  be;

  assign req   = mem_read | mem_write;
  assign acc   = acc_t'({mem_write, mem_read});
  assign legal = is_legal(acc, funct3, addr, DEPTH);
  assign rword = mem[idx_q];

  dmem_align u_align (
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .wdata   (wdata_q),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .lword   (lword)
  );

  // Next-state, request latching and completion results.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = addr[IW+1:2];
          lo_d    = addr[1:0];
          wdata_d = wdata;
          f3_d    = funct3;
          wr_d    = mem_write;
          bad_d   = ~legal;
          if (legal) begin
            state_d = WAIT;
            cnt_d   = CW'(LAT - 1);
          end else begin
            // Faulting access skips the RAM entirely and completes next cycle.
            state_d = DONE;
            rdata_d = '0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (wr_q) begin
            mem_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = lword;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == DONE);
  assign fault = (state_q == DONE) & bad_q;
  assign stall = ~rst & ((state_q == WAIT) | ((state_q == IDLE) & req));

endmodule
